// File: rtl/block_pkg.sv
// Shared types and defaults for the stacker block bitmap controller.
package block_pkg;

  localparam int DEF_ROWS        = 8;
  localparam int DEF_COLS        = 8;
  localparam int DEF_FLASH_COUNT = 6;

  typedef logic [$clog2(DEF_ROWS)-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FLASH = 2'd2
  } state_t;

endpackage

// File: rtl/bitmap_store.sv
// Block bitmap register file: one write port, one clear-row port and a
// registered single-bit read port whose output is XORed with an invert mask.
module bitmap_store
  import block_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  input  logic                    clr_en,
  input  logic [$clog2(ROWS)-1:0] clr_row,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  input  logic [$clog2(COLS)-1:0] rd_col,
  input  logic                    rd_mask,
  output logic                    rd_pixel
);

  localparam int CW = $clog2(COLS);

  logic [COLS-1:0] bitmap [ROWS];
  logic [CW-1:0]   col_idx;

  // Column 0 on screen is the most significant bit of the row word.
  assign col_idx = CW'(COLS - 1) - rd_col;

  // NOTE: the array is reset explicitly; the game relies on an empty board
  // after reset, so this must stay flops rather than an unreset RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) bitmap[r] <= '0;
      rd_pixel <= 1'b0;
    end else begin
      if (clr_en)     bitmap[clr_row] <= '0;
      else if (wr_en) bitmap[wr_row]  <= wr_data;
      rd_pixel <= bitmap[rd_row][col_idx] ^ rd_mask;
    end
  end

endmodule

// File: rtl/block_array_ctrl.sv
// Arbitrates FSM row writes, a multi-cycle bitmap clear and the game-over
// flash animation, and serves the VGA pixel read path.
module block_array_ctrl
  import block_pkg::*;
#(
  parameter int ROWS        = DEF_ROWS,
  parameter int COLS        = DEF_COLS,
  parameter int FLASH_COUNT = DEF_FLASH_COUNT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_req,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  output logic                    wr_ack,
  input  logic                    clr_req,
  output logic                    clr_busy,
  output logic                    clr_done,
  input  logic                    flash_req,
  input  logic                    flash_tick,
  output logic                    flash_active,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  input  logic [$clog2(COLS)-1:0] rd_col,
  output logic                    rd_pixel
);

  localparam int RW    = $clog2(ROWS);
  localparam int CNT_W = $clog2(FLASH_COUNT + 1);

  state_t           state, state_d;
  logic [RW-1:0]    clr_ptr, clr_ptr_d;
  logic [CNT_W-1:0] flash_cnt, flash_cnt_d;
  logic             invert, invert_d;
  logic             wr_ack_d, clr_busy_d, clr_done_d, flash_active_d;
  logic             wr_en, clr_en;
  logic [RW-1:0]    wr_idx;

  // FSM row 0 is the bottom of the stack, stored in the last bitmap row.
  assign wr_idx = RW'(ROWS - 1) - wr_row;

  // NOTE: every signal gets its default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state;
    clr_ptr_d      = clr_ptr;
    flash_cnt_d    = flash_cnt;
    invert_d       = invert;
    wr_ack_d       = 1'b0;
    clr_busy_d     = clr_busy;
    clr_done_d     = 1'b0;
    flash_active_d = flash_active;
    wr_en          = 1'b0;
    clr_en         = 1'b0;

    case (state)
      IDLE: begin
        if (clr_req) begin
          state_d    = CLEAR;
          clr_ptr_d  = '0;
          clr_busy_d = 1'b1;
        end else if (wr_req) begin
          // A request still high during its own ack cycle is not re-accepted.
          if (!wr_ack) begin
            wr_en    = 1'b1;
            wr_ack_d = 1'b1;
          end
        end else if (flash_req) begin
          state_d        = FLASH;
          flash_cnt_d    = '0;
          flash_active_d = 1'b1;
        end
      end
      CLEAR: begin
        clr_en = 1'b1;
        if (clr_ptr == RW'(ROWS - 1)) begin
          state_d    = IDLE;
          clr_busy_d = 1'b0;
          clr_done_d = 1'b1;
        end else begin
          clr_ptr_d = clr_ptr + 1'b1;
        end
      end
      FLASH: begin
        if (clr_req) begin
          state_d        = CLEAR;
          clr_ptr_d      = '0;
          clr_busy_d     = 1'b1;
          invert_d       = 1'b0;
          flash_active_d = 1'b0;
        end else if (flash_tick) begin
          if (flash_cnt == CNT_W'(FLASH_COUNT - 1)) begin
            state_d        = IDLE;
            flash_cnt_d    = CNT_W'(FLASH_COUNT);
            invert_d       = 1'b0;
            flash_active_d = 1'b0;
          end else begin
            flash_cnt_d = flash_cnt + 1'b1;
            invert_d    = ~invert;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      clr_ptr      <= '0;
      flash_cnt    <= '0;
      invert       <= 1'b0;
      wr_ack       <= 1'b0;
      clr_busy     <= 1'b0;
      clr_done     <= 1'b0;
      flash_active <= 1'b0;
    end else begin
      state        <= state_d;
      clr_ptr      <= clr_ptr_d;
      flash_cnt    <= flash_cnt_d;
      invert       <= invert_d;
      wr_ack       <= wr_ack_d;
      clr_busy     <= clr_busy_d;
      clr_done     <= clr_done_d;
      flash_active <= flash_active_d;
    end
  end

  bitmap_store #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_row   (wr_idx),
    .wr_data  (wr_data),
    .clr_en   (clr_en),
    .clr_row  (clr_ptr),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_mask  (invert),
    .rd_pixel (rd_pixel)
  );

endmodule

// File: tb/tb_block_array_ctrl.sv
// Directed bench for block_array_ctrl: writes, clear, flash, abort and reset.
module tb_block_array_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_req;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       clr_req;
  logic       clr_busy;
  logic       clr_done;
  logic       flash_req;
  logic       flash_tick;
  logic       flash_active;
  logic [2:0] rd_row;
  logic [2:0] rd_col;
  logic       rd_pixel;

  int checks = 0;
  int errors = 0;

  block_array_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .wr_req       (wr_req),
    .wr_row       (wr_row),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .clr_req      (clr_req),
    .clr_busy     (clr_busy),
    .clr_done     (clr_done),
    .flash_req    (flash_req),
    .flash_tick   (flash_tick),
    .flash_active (flash_active),
    .rd_row       (rd_row),
    .rd_col       (rd_col),
    .rd_pixel     (rd_pixel)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [2:0] row, input logic [7:0] data);
    int n = 0;
    wr_row  = row;
    wr_data = data;
    wr_req  = 1'b1;
    do begin
      step(1);
      n++;
    end while (!wr_ack && n < 50);
    wr_req = 1'b0;
    check("write ack", wr_ack, 1'b1);
  endtask

  task automatic read_row(input logic [2:0] row, output logic [7:0] v);
    v = '0;
    for (int c = 0; c < 8; c++) begin
      rd_row = row;
      rd_col = 3'(c);
      step(1);
      v[7-c] = rd_pixel;
    end
  endtask

  // Count samples with clr_busy high, starting from the current sample.
  task automatic count_busy(output int n);
    n = 0;
    while (clr_busy && n < 20) begin
      n++;
      step(1);
    end
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] exp_row;
    int         n;
    int         ones;
    logic       ack_seen;

    reset = 1'b1; wr_req = 0; wr_row = 0; wr_data = 0; clr_req = 0;
    flash_req = 0; flash_tick = 0; rd_row = 0; rd_col = 0;
    step(3);
    check("reset wr_ack", wr_ack, 1'b0);
    check("reset clr_busy", clr_busy, 1'b0);
    check("reset clr_done", clr_done, 1'b0);
    check("reset flash_active", flash_active, 1'b0);
    check("reset rd_pixel", rd_pixel, 1'b0);
    reset = 1'b0;
    step(1);

    // 1: single write, ack latency and pulse width, pixel mapping
    wr_row = 3'd0; wr_data = 8'hF0; wr_req = 1'b1;
    step(1);
    check("t1 ack latency", wr_ack, 1'b1);
    wr_req = 1'b0;
    step(1);
    check("t1 ack pulse", wr_ack, 1'b0);
    for (int c = 0; c < 8; c++) begin
      rd_row = 3'd7;
      rd_col = 3'(c);
      step(1);
      check($sformatf("t1 pixel col%0d", c), rd_pixel, (c < 4) ? 1'b1 : 1'b0);
    end

    // 2: fill every row, then a pulsed clear
    for (int r = 0; r < 8; r++) write_row(3'(r), 8'hFF);
    step(1);
    read_row(3'd3, v);
    check("t2 filled row", v, 8'hFF);
    clr_req = 1'b1;
    step(1);
    clr_req = 1'b0;
    count_busy(n);
    check("t2 busy cycles", n, 8);
    check("t2 clr_done", clr_done, 1'b1);
    step(1);
    check("t2 clr_done pulse", clr_done, 1'b0);
    ones = 0;
    for (int r = 0; r < 8; r++) begin
      read_row(3'(r), v);
      ones += $countones(v);
    end
    check("t2 all clear", ones, 0);

    // 3: clear beats a simultaneous write; the write is served afterwards
    clr_req = 1'b1; wr_req = 1'b1; wr_row = 3'd2; wr_data = 8'h18;
    step(1);
    clr_req = 1'b0;
    ack_seen = 1'b0;
    n = 0;
    while (clr_busy && n < 20) begin
      ack_seen |= wr_ack;
      n++;
      step(1);
    end
    check("t3 busy cycles", n, 8);
    check("t3 no ack in clear", ack_seen | wr_ack, 1'b0);
    step(1);
    check("t3 ack after clear", wr_ack, 1'b1);
    wr_req = 1'b0;
    for (int r = 0; r < 8; r++) begin
      read_row(3'(r), v);
      exp_row = (r == 5) ? 8'h18 : 8'h00;
      check($sformatf("t3 row%0d", r), v, exp_row);
    end

    // 4: full flash; a tick on the entry edge must not count
    write_row(3'd0, 8'h81);
    rd_row = 3'd7; rd_col = 3'd1;
    flash_req = 1'b1; flash_tick = 1'b1;
    step(1);
    flash_req = 1'b0; flash_tick = 1'b0;
    check("t4 flash_active", flash_active, 1'b1);
    step(1);
    check("t4 pixel before ticks", rd_pixel, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      flash_tick = 1'b1;
      step(1);
      flash_tick = 1'b0;
      step(1);
      check($sformatf("t4 pixel tick%0d", k), rd_pixel, (k % 2 == 1) ? 1'b1 : 1'b0);
      check($sformatf("t4 active tick%0d", k), flash_active, (k < 6) ? 1'b1 : 1'b0);
    end
    step(2);
    check("t4 final pixel", rd_pixel, 1'b0);

    // 5: clear aborts the flash after three ticks
    flash_req = 1'b1;
    step(1);
    flash_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      flash_tick = 1'b1;
      step(1);
      flash_tick = 1'b0;
      step(1);
    end
    check("t5 inverted pixel", rd_pixel, 1'b1);
    clr_req = 1'b1;
    step(1);
    clr_req = 1'b0;
    check("t5 abort active", flash_active, 1'b0);
    check("t5 abort busy", clr_busy, 1'b1);
    n = 1;
    step(1);
    check("t5 invert cleared", rd_pixel, 1'b0);
    while (clr_busy && n < 20) begin
      n++;
      step(1);
    end
    check("t5 busy cycles", n, 8);
    check("t5 clr_done", clr_done, 1'b1);

    // 6: reset in the middle of a clear
    write_row(3'd0, 8'hAA);
    step(1);
    clr_req = 1'b1;
    step(1);
    clr_req = 1'b0;
    rd_row = 3'd7; rd_col = 3'd0;
    step(3);
    check("t6 busy before reset", clr_busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("t6 reset clr_busy", clr_busy, 1'b0);
    check("t6 reset clr_done", clr_done, 1'b0);
    check("t6 reset wr_ack", wr_ack, 1'b0);
    check("t6 reset flash_active", flash_active, 1'b0);
    check("t6 reset rd_pixel", rd_pixel, 1'b0);
    step(2);
    reset = 1'b0;
    read_row(3'd7, v);
    check("t6 row7 cleared by reset", v, 8'h00);
    wr_row = 3'd3; wr_data = 8'h3C; wr_req = 1'b1;
    step(1);
    check("t6 ack after reset", wr_ack, 1'b1);
    wr_req = 1'b0;
    read_row(3'd4, v);
    check("t6 row4 written", v, 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
